// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the adder_arbiter block.
// ADDER_ARB_FIXED_PRIO_EN (optional) selects fixed-priority arbitration.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 2;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational winner picker: round-robin from ptr, or lowest index first
// when ADDER_ARB_FIXED_PRIO_EN is defined.
module adder_arb_rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req_masked,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] cand_s;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr;
`endif

    // First requesting candidate in search order wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand_s = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            cand_s = IW'(i);
`else
            cand_s = IW'((int'(ptr) + i) % NREQ);
`endif
            if (!found && req_masked[cand_s]) begin
                found          = 1'b1;
                onehot[cand_s] = 1'b1;
                idx            = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Arbiter/sequencer sharing one combinational adder among NREQ requesters.
// ADDER_ARB_FIXED_PRIO_EN (optional) replaces round-robin with fixed priority.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0][WIDTH-1:0]  a_i,
    input  logic [NREQ-1:0][WIDTH-1:0]  b_i,
    input  logic [NREQ-1:0]             cin_i,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic [WIDTH-1:0]            sum_o,
    output logic                        cout_o,
    output logic                        busy,
    output logic [WIDTH-1:0]            add_a,
    output logic [WIDTH-1:0]            add_b,
    output logic                        add_cin,
    input  logic [WIDTH-1:0]            add_sum,
    input  logic                        add_cout
);

    localparam int IW = idx_w(NREQ);

    state_e            state_r, next_s;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              cin_r;
    logic [NREQ-1:0]   gnt_r, done_r, mask_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r, busy_r;
    logic [IW-1:0]     ptr_s;

    logic [NREQ-1:0]   pick_onehot_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_found_s;
    logic              take_s;
    logic [NREQ-1:0]   gnt_d_s, done_d_s;
    logic              busy_d_s;

    adder_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_masked (req & ~mask_r),
        .ptr        (ptr_s),
        .onehot     (pick_onehot_s),
        .idx        (pick_idx_s),
        .found      (pick_found_s)
    );

    assign take_s = (state_r == IDLE) && pick_found_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic: one transaction is always IDLE -> EXEC -> RESP.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = pick_found_s ? EXEC : IDLE;
            EXEC:    next_s = RESP;
            RESP:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // FSM output decode: adder drive plus next values of registered outputs.
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        gnt_d_s  = '0;
        done_d_s = '0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    gnt_d_s = pick_onehot_s;
                end else begin
                    gnt_d_s = '0;
                end
            end
            EXEC: begin
                add_a    = a_r;
                add_b    = b_r;
                add_cin  = cin_r;
                done_d_s = gnt_r;
            end
            RESP: begin
                done_d_s = '0;
            end
            default: begin
                gnt_d_s  = '0;
                done_d_s = '0;
            end
        endcase
        busy_d_s = (next_s != IDLE);
    end

    // Output registers, operand latch and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= '0;
            done_r <= '0;
            busy_r <= 1'b0;
            mask_r <= '0;
            a_r    <= '0;
            b_r    <= '0;
            cin_r  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            gnt_r  <= gnt_d_s;
            done_r <= done_d_s;
            busy_r <= busy_d_s;
            // done is only set in RESP, so this masks exactly the next IDLE cycle
            mask_r <= done_r;
            if (take_s) begin
                a_r   <= a_i[pick_idx_s];
                b_r   <= b_i[pick_idx_s];
                cin_r <= cin_i[pick_idx_s];
            end else begin
                a_r   <= a_r;
                b_r   <= b_r;
                cin_r <= cin_r;
            end
            if (state_r == EXEC) begin
                sum_r  <= add_sum;
                cout_r <= add_cout;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign ptr_s = '0;
`else
    logic [IW-1:0] ptr_r;

    // Round-robin pointer: index just after the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (take_s) begin
            if (int'(pick_idx_s) == NREQ - 1) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= pick_idx_s + IW'(1'b1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    assign gnt    = gnt_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign sum_o  = sum_r;
    assign cout_o = cout_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (default round-robin build).
module tb_adder_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][1:0]  a_i;
    logic [3:0][1:0]  b_i;
    logic [3:0]       cin_i;
    logic [3:0]       gnt;
    logic [3:0]       done;
    logic [1:0]       sum_o;
    logic             cout_o;
    logic             busy;
    logic [1:0]       add_a;
    logic [1:0]       add_b;
    logic             add_cin;
    logic [1:0]       add_sum;
    logic             add_cout;

    int vecs;
    int miss;

    adder_arbiter #(.NREQ(4), .WIDTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_i      (a_i),
        .b_i      (b_i),
        .cin_i    (cin_i),
        .gnt      (gnt),
        .done     (done),
        .sum_o    (sum_o),
        .cout_o   (cout_o),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // The shared adder that the arbiter fronts.
    assign {add_cout, add_sum} = add_a + add_b + {1'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] order_rr [5];
    logic [2:0] res_rr   [4];
    logic [1:0] order_mk [4];

    initial begin
        vecs  = 0;
        miss  = 0;
        req   = 4'b0000;
        a_i   = '0;
        b_i   = '0;
        cin_i = 4'b0000;
        order_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        res_rr   = '{3'b010, 3'b011, 3'b100, 3'b101};
        order_mk = '{2'd0, 2'd2, 2'd0, 2'd2};

        // Reset state
        rst_n = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sum", 32'({cout_o, sum_o}), 32'h0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: 01 + 10 + 0 = 011
        req      = 4'b0001;
        a_i[0]   = 2'b01;
        b_i[0]   = 2'b10;
        cin_i[0] = 1'b0;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_add", 32'({add_a, add_b, add_cin}), 32'b01_10_0);
        req = 4'b0000;
        tick();
        chk("single_done", 32'(done), 32'h1);
        chk("single_res", 32'({cout_o, sum_o}), 32'b011);
        chk("single_gnt_clr", 32'(gnt), 32'h0);
        tick();
        chk("single_idle_done", 32'(done), 32'h0);
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_hold", 32'(sum_o), 32'b11);

        // Overflow: 11 + 01 + 1 = 101
        req      = 4'b0010;
        a_i[1]   = 2'b11;
        b_i[1]   = 2'b01;
        cin_i[1] = 1'b1;
        tick();
        chk("ovf_gnt", 32'(gnt), 32'h2);
        chk("ovf_add", 32'({add_a, add_b, add_cin}), 32'b11_01_1);
        req = 4'b0000;
        tick();
        chk("ovf_done", 32'(done), 32'h2);
        chk("ovf_res", 32'({cout_o, sum_o}), 32'b101);
        chk("ovf_add_zero", 32'({add_a, add_b, add_cin}), 32'h0);
        tick();

        // Contention: all four held after reset; a[k]=k, b=01, cin=1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_i[k]   = 2'(k);
            b_i[k]   = 2'b01;
            cin_i[k] = 1'b1;
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("cont_gnt", 32'(gnt), 32'(4'b0001 << order_rr[n]));
            chk("cont_onehot", 32'($onehot(gnt)), 32'h1);
            tick();
            chk("cont_done", 32'(done), 32'(4'b0001 << order_rr[n]));
            chk("cont_res", 32'({cout_o, sum_o}), 32'(res_rr[order_rr[n]]));
            tick();
            chk("cont_idle", 32'({busy, gnt, done}), 32'h0);
        end
        req = 4'b0000;

        // Mask and fairness: req[0] and req[2] held
        do_reset();
        req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("mask_gnt", 32'(gnt), 32'(4'b0001 << order_mk[n]));
            tick();
            chk("mask_done", 32'(done), 32'(4'b0001 << order_mk[n]));
            tick();
        end
        req = 4'b0000;
        tick();

        // Operand stability: 10 + 11 + 1 = 110, operands changed during EXEC
        req      = 4'b0001;
        a_i[0]   = 2'b10;
        b_i[0]   = 2'b11;
        cin_i[0] = 1'b1;
        tick();
        chk("stab_gnt", 32'(gnt), 32'h1);
        a_i[0] = 2'b00;
        req    = 4'b0000;
        tick();
        chk("stab_done", 32'(done), 32'h1);
        chk("stab_res", 32'({cout_o, sum_o}), 32'b110);
        tick();

        // Reset in EXEC, then requester 2 wins first (01 + 10 + 0 = 011)
        req      = 4'b0010;
        a_i[1]   = 2'b01;
        b_i[1]   = 2'b01;
        cin_i[1] = 1'b0;
        a_i[2]   = 2'b01;
        b_i[2]   = 2'b10;
        cin_i[2] = 1'b0;
        tick();
        chk("rexec_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        req   = 4'b0100;
        #1;
        chk("rexec_outs", 32'({gnt, done, busy}), 32'h0);
        chk("rexec_res", 32'({cout_o, sum_o}), 32'h0);
        chk("rexec_add", 32'({add_a, add_b, add_cin}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rexec_gnt2", 32'(gnt), 32'h4);
        chk("rexec_nodone", 32'(done), 32'h0);
        req = 4'b0000;
        tick();
        chk("rexec_done2", 32'(done), 32'h4);
        chk("rexec_res2", 32'({cout_o, sum_o}), 32'b011);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
